sim_result_monitor: RTL and testbench
=====================================

// Module: sim_result_monitor
// PURPOSE
//   Cycle-accurate run monitor for the CHIP core bench. Watches the instruction fetch
//   address for a halt PC or an abort PC, enforces a cycle budget, then serially compares
//   NUM_CHK result channels against expected values. Reports pass/fail, the cause, and the
//   mismatch count. Replaces hard-coded end-PC/a0 checks in per-program benches.
// PARAMETERS
//   ADDR_W     32            fetch address width
//   DATA_W     32            width of each result/expect channel
//   NUM_CHK    4             number of result channels compared (>=1)
//   CNT_W      16            width of cycle counter and timeout limit
//   HALT_PC    32'h000010E4  fetch address that ends the run normally
//   ABORT_PC   32'h000000C0  fetch address that ends the run as an abort
// PORTS
//   clk            in   1               clock, all state updates on rising edge
//   rst            in   1               synchronous reset, active-high
//   start          in   1               1-cycle pulse: arm the monitor
//   pc             in   ADDR_W          current instruction fetch address (mem_addr_I)
//   result         in   NUM_CHK*DATA_W  flattened observed values; channel k = [k*DATA_W +: DATA_W]
//   expect_val     in   NUM_CHK*DATA_W  flattened expected values, same packing
//   chk_mask       in   NUM_CHK         1 = channel k compared; 0 = skipped (never a mismatch)
//   timeout_limit  in   CNT_W           cycle budget; 0 = no timeout
//   busy           out  1               1 in RUN or CHECK
//   done           out  1               1 in DONE; held until start or rst
//   pass           out  1               valid when done: cause==HALT and err_cnt==0
//   cause          out  2               0 NONE, 1 HALT, 2 ABORT, 3 TIMEOUT
//   err_cnt        out  $clog2(NUM_CHK+1)  number of mismatching channels
//   mismatch_vec   out  NUM_CHK         bit k set when channel k mismatched
//   cycle_cnt      out  CNT_W           RUN cycles elapsed; saturates at all-ones
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, pass, cause, err_cnt, mismatch_vec, cycle_cnt all 0.
//   States: IDLE, RUN, CHECK, DONE.
//   IDLE: start -> RUN; cycle_cnt, err_cnt, mismatch_vec, cause, pass cleared the same edge.
//   RUN: cycle_cnt +1 per cycle (saturating). Exit checks, priority high to low:
//     pc==HALT_PC  -> CHECK, cause=HALT, channel index idx=0
//     pc==ABORT_PC -> DONE,  cause=ABORT, pass=0
//     timeout_limit!=0 and cycle_cnt==timeout_limit-1 -> DONE, cause=TIMEOUT, pass=0
//     pc sampled in the same cycle counts (first RUN cycle may halt immediately).
//     start while RUN or CHECK ignored.
//   CHECK: one channel per cycle, idx 0..NUM_CHK-1, sampling result/expect_val that cycle.
//     chk_mask[idx]=1 and values differ -> mismatch_vec[idx]=1, err_cnt+1.
//     After idx==NUM_CHK-1 -> DONE; pass = (final err_cnt==0). Latency HALT->done = NUM_CHK+1.
//     cycle_cnt frozen during CHECK and DONE.
//   DONE: all status outputs held. start -> clears status as in IDLE, enters RUN (re-arm).
//   Compare is full-width, 4-state-unaware (x inputs are bench error, not spec'd).
//   rst mid-RUN/CHECK: returns to IDLE next edge, all outputs 0, partial results discarded.
//   Simultaneous rst and start: rst wins.
// TESTING
//   1 start, pc reaches 0x10E4 at cycle 50, result==expect on all 4 ch, mask=4'hF
//     -> done at HALT+5 cycles, pass=1, cause=1, err_cnt=0, cycle_cnt=51.
//   2 as 1 but ch2 result=5, expect=6, ch3 masked off with mismatch
//     -> pass=0, err_cnt=1, mismatch_vec=4'b0100.
//   3 pc hits 0xC0 at cycle 10 -> done next edge, cause=2, pass=0, mismatch_vec=0.
//   4 timeout_limit=100, pc never halts -> done after exactly 100 RUN cycles, cause=3;
//     timeout_limit=0 -> busy stays 1 for 1000 cycles.
//   5 rst asserted during CHECK idx=1 -> next cycle all outputs 0, IDLE; new start runs clean.
//   6 start during DONE -> status cleared, busy=1 next cycle; start during RUN has no effect.

Source files
------------

// File: rtl/sim_result_monitor_if.sv
// Bundles the run-control inputs and status outputs of sim_result_monitor.
//   master : bench side, drives start/pc/result/expect_val/chk_mask/timeout_limit
//   slave  : monitor side, drives busy/done/pass/cause/err_cnt/mismatch_vec/cycle_cnt
interface sim_result_monitor_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_CHK = 4,
    parameter int CNT_W   = 16
);
    localparam int ERR_W = $clog2(NUM_CHK + 1);

    logic                        start;
    logic [ADDR_W-1:0]           pc;
    logic [NUM_CHK*DATA_W-1:0]   result;
    logic [NUM_CHK*DATA_W-1:0]   expect_val;
    logic [NUM_CHK-1:0]          chk_mask;
    logic [CNT_W-1:0]            timeout_limit;

    logic                        busy;
    logic                        done;
    logic                        pass;
    logic [1:0]                  cause;
    logic [ERR_W-1:0]            err_cnt;
    logic [NUM_CHK-1:0]          mismatch_vec;
    logic [CNT_W-1:0]            cycle_cnt;

    modport master (
        output start, pc, result, expect_val, chk_mask, timeout_limit,
        input  busy, done, pass, cause, err_cnt, mismatch_vec, cycle_cnt
    );

    modport slave (
        input  start, pc, result, expect_val, chk_mask, timeout_limit,
        output busy, done, pass, cause, err_cnt, mismatch_vec, cycle_cnt
    );
endinterface

// File: rtl/sim_result_monitor.sv
// Run monitor for the core bench: watches the fetch address for a halt or abort PC,
// enforces a cycle budget, then compares the result channels one per cycle against
// their expected values and reports pass/fail, cause and mismatch count.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : sim_result_monitor_if.slave (start/pc/result/expect_val/chk_mask/timeout_limit
//          in; busy/done/pass/cause/err_cnt/mismatch_vec/cycle_cnt out)
//
// state   | meaning
// S_IDLE  | waiting for start, status cleared
// S_RUN   | counting cycles, watching pc for halt/abort, checking timeout
// S_CHECK | comparing channel idx, one per cycle
// S_DONE  | status held until start (re-arm) or rst
module sim_result_monitor #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              NUM_CHK  = 4,
    parameter int              CNT_W    = 16,
    parameter logic [ADDR_W-1:0] HALT_PC  = ADDR_W'(32'h000010E4),
    parameter logic [ADDR_W-1:0] ABORT_PC = ADDR_W'(32'h000000C0)
) (
    input  logic clk,
    input  logic rst,
    sim_result_monitor_if.slave bus
);
    localparam int ERR_W = $clog2(NUM_CHK + 1);
    localparam int IDX_W = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_HALT    = 2'd1;
    localparam logic [1:0] CAUSE_ABORT   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [1:0]         cause, cause_nxt;
    logic               pass, pass_nxt;
    logic [ERR_W-1:0]   err_cnt, err_nxt;
    logic [NUM_CHK-1:0] mis_vec, mis_nxt;
    logic [CNT_W-1:0]   cyc_cnt, cyc_nxt;
    logic [DATA_W-1:0]  res_sel, exp_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            cause   <= CAUSE_NONE;
            pass    <= 1'b0;
            err_cnt <= '0;
            mis_vec <= '0;
            cyc_cnt <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cause   <= cause_nxt;
            pass    <= pass_nxt;
            err_cnt <= err_nxt;
            mis_vec <= mis_nxt;
            cyc_cnt <= cyc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cause_nxt = cause;
        pass_nxt  = pass;
        err_nxt   = err_cnt;
        mis_nxt   = mis_vec;
        cyc_nxt   = cyc_cnt;
        res_sel   = bus.result[idx*DATA_W +: DATA_W];
        exp_sel   = bus.expect_val[idx*DATA_W +: DATA_W];

        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_nxt = S_RUN;
                    idx_nxt   = '0;
                    cause_nxt = CAUSE_NONE;
                    pass_nxt  = 1'b0;
                    err_nxt   = '0;
                    mis_nxt   = '0;
                    cyc_nxt   = '0;
                end
            end
            S_RUN: begin
                // The exiting cycle is itself counted as a RUN cycle.
                if (cyc_cnt != '1)
                    cyc_nxt = cyc_cnt + CNT_W'(1);
                if (bus.pc == HALT_PC) begin
                    state_nxt = S_CHECK;
                    cause_nxt = CAUSE_HALT;
                    idx_nxt   = '0;
                end else if (bus.pc == ABORT_PC) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_ABORT;
                    pass_nxt  = 1'b0;
                end else if (bus.timeout_limit != '0 &&
                             cyc_cnt == bus.timeout_limit - CNT_W'(1)) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_TIMEOUT;
                    pass_nxt  = 1'b0;
                end
            end
            S_CHECK: begin
                if (bus.chk_mask[idx] && (res_sel != exp_sel)) begin
                    mis_nxt[idx] = 1'b1;
                    err_nxt      = err_cnt + ERR_W'(1);
                end
                if (idx == IDX_W'(NUM_CHK - 1)) begin
                    state_nxt = S_DONE;
                    pass_nxt  = (err_nxt == '0);
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy         = (state == S_RUN) || (state == S_CHECK);
    assign bus.done         = (state == S_DONE);
    assign bus.pass         = pass;
    assign bus.cause        = cause;
    assign bus.err_cnt      = err_cnt;
    assign bus.mismatch_vec = mis_vec;
    assign bus.cycle_cnt    = cyc_cnt;
endmodule

// File: tb/tb_sim_result_monitor.sv
module tb_sim_result_monitor;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_CHK = 4;
    localparam int CNT_W   = 16;
    localparam logic [31:0] HALT  = 32'h000010E4;
    localparam logic [31:0] ABORT = 32'h000000C0;
    localparam int INF = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sim_result_monitor_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CHK(NUM_CHK), .CNT_W(CNT_W)) bus ();

    sim_result_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CHK(NUM_CHK), .CNT_W(CNT_W),
        .HALT_PC(HALT), .ABORT_PC(ABORT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] res_ch [NUM_CHK];
    logic [31:0] exp_ch [NUM_CHK];
    logic [3:0]  mask;

    // Run-level model: each run is described by the RUN cycle index at which it exits,
    // and the final status it must report; per-cycle expectations follow from that.
    bit          m_valid = 1'b1;
    bit          m_idle  = 1'b1;
    int          m_e0, m_run_len, m_chk_len, m_h, m_a, m_cause, m_err, m_cyc;
    logic [3:0]  m_mis;
    bit          m_pass;
    int          cj;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit b, input bit d, input int c,
                             input bit p, input int e, input logic [3:0] mv, input int cc);
        chk({tag, "_busy"},  64'(bus.busy), 64'(b));
        chk({tag, "_done"},  64'(bus.done), 64'(d));
        chk({tag, "_cause"}, 64'(bus.cause), 64'(c));
        chk({tag, "_pass"},  64'(bus.pass), 64'(p));
        chk({tag, "_err"},   64'(bus.err_cnt), 64'(e));
        chk({tag, "_mis"},   64'(bus.mismatch_vec), 64'(mv));
        chk({tag, "_cyc"},   64'(bus.cycle_cnt), 64'(cc));
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            if (m_idle) begin
                check_all("idle", 0, 0, 0, 0, 0, 4'h0, 0);
            end else begin
                cj = cyc - m_e0;
                if (cj < m_run_len) begin
                    check_all("run", 1, 0, 0, 0, 0, 4'h0, cj);
                end else if (cj < m_run_len + m_chk_len) begin
                    chk("check_busy",  64'(bus.busy), 64'd1);
                    chk("check_done",  64'(bus.done), 64'd0);
                    chk("check_cause", 64'(bus.cause), 64'd1);
                    chk("check_cyc",   64'(bus.cycle_cnt), 64'(m_cyc));
                end else begin
                    check_all("done", 0, 1, m_cause, m_pass, m_err, m_mis, m_cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_data();
        for (int i = 0; i < NUM_CHK; i++) begin
            bus.result[i*DATA_W +: DATA_W]     = res_ch[i];
            bus.expect_val[i*DATA_W +: DATA_W] = exp_ch[i];
        end
        bus.chk_mask = mask;
    endtask

    // h/a: RUN cycle index where pc shows HALT/ABORT (-1 = never); lim: timeout budget.
    task automatic launch(input int h, input int a, input int lim);
        int k;
        int c;
        int e;
        logic [3:0] mv;
        k = INF; c = 0; e = 0; mv = 4'h0;
        if (h >= 0) begin k = h; c = 1; end
        if (a >= 0 && a < k) begin k = a; c = 2; end
        if (lim != 0 && lim - 1 < k) begin k = lim - 1; c = 3; end
        if (c == 1)
            for (int i = 0; i < NUM_CHK; i++)
                if (mask[i] && res_ch[i] != exp_ch[i]) begin
                    mv[i] = 1'b1;
                    e++;
                end
        apply_data();
        bus.timeout_limit = CNT_W'(lim);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_e0      = cyc;
        m_idle    = 1'b0;
        m_run_len = (c == 0) ? INF : k + 1;
        m_chk_len = (c == 1) ? NUM_CHK : 0;
        m_cause   = c;
        m_err     = e;
        m_mis     = mv;
        m_pass    = (c == 1) && (e == 0);
        m_cyc     = k + 1;
        m_h       = h;
        m_a       = a;
    endtask

    task automatic drive_pc(input int n, input int start_at);
        for (int j = 0; j < n; j++) begin
            if (j == m_h)      bus.pc = HALT;
            else if (j == m_a) bus.pc = ABORT;
            else               bus.pc = 32'h00002000 + 32'(4 * j);
            bus.start = (j == start_at);
            tick();
        end
        bus.start = 1'b0;
        bus.pc    = 32'h00003000;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!bus.done && n < bound) begin
            tick();
            n++;
        end
        chk("done_reached", 64'(bus.done), 64'd1);
    endtask

    task automatic do_reset(input bit with_start);
        m_valid   = 1'b0;
        rst       = 1'b1;
        bus.start = with_start;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        m_idle    = 1'b1;
        m_valid   = 1'b1;
    endtask

    task automatic set_equal_data();
        for (int i = 0; i < NUM_CHK; i++) begin
            res_ch[i] = 32'h1000_0011 * (i + 1);
            exp_ch[i] = 32'h1000_0011 * (i + 1);
        end
        mask = 4'hF;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pc = 32'h0;
        bus.timeout_limit = '0;
        set_equal_data();
        apply_data();

        repeat (3) tick();
        check_all("reset", 0, 0, 0, 0, 0, 4'h0, 0);
        rst = 1'b0;
        tick();

        // 1: clean halt at RUN cycle 50
        launch(50, -1, 0);
        drive_pc(51, -1);
        wait_done(20);
        chk("t1_latency", 64'(cyc - m_e0), 64'd55);
        chk("t1_pass",    64'(bus.pass), 64'd1);
        chk("t1_cause",   64'(bus.cause), 64'd1);
        chk("t1_err",     64'(bus.err_cnt), 64'd0);
        chk("t1_cyc",     64'(bus.cycle_cnt), 64'd51);
        tick();

        // 2: ch2 mismatches, ch3 mismatches but is masked off (re-armed from DONE)
        res_ch[2] = 32'd5;  exp_ch[2] = 32'd6;
        res_ch[3] = 32'd99; exp_ch[3] = 32'd7;
        mask = 4'b0111;
        launch(50, -1, 0);
        drive_pc(51, -1);
        wait_done(20);
        chk("t2_pass", 64'(bus.pass), 64'd0);
        chk("t2_err",  64'(bus.err_cnt), 64'd1);
        chk("t2_mis",  64'(bus.mismatch_vec), 64'h4);
        tick();

        // 3: abort at RUN cycle 10
        launch(-1, 10, 0);
        drive_pc(11, -1);
        chk("t3_done_next", 64'(bus.done), 64'd1);
        chk("t3_cause",     64'(bus.cause), 64'd2);
        chk("t3_pass",      64'(bus.pass), 64'd0);
        chk("t3_mis",       64'(bus.mismatch_vec), 64'h0);
        tick();

        // 6 + 4: start in DONE re-arms and clears; timeout after exactly 100 RUN cycles
        launch(-1, -1, 100);
        chk("t6_busy",  64'(bus.busy), 64'd1);
        chk("t6_done",  64'(bus.done), 64'd0);
        chk("t6_cause", 64'(bus.cause), 64'd0);
        drive_pc(100, -1);
        wait_done(5);
        chk("t4_len",   64'(cyc - m_e0), 64'd100);
        chk("t4_cause", 64'(bus.cause), 64'd3);
        chk("t4_cyc",   64'(bus.cycle_cnt), 64'd100);
        tick();

        // priority: halt / abort on the same cycle the budget runs out
        set_equal_data();
        launch(19, -1, 20);
        drive_pc(20, -1);
        wait_done(10);
        chk("prio_halt_cause", 64'(bus.cause), 64'd1);
        launch(-1, 19, 20);
        drive_pc(20, -1);
        wait_done(5);
        chk("prio_abort_cause", 64'(bus.cause), 64'd2);

        // halt on the very first RUN cycle, every channel mismatching
        for (int i = 0; i < NUM_CHK; i++) exp_ch[i] = ~res_ch[i];
        launch(0, -1, 0);
        drive_pc(1, -1);
        wait_done(10);
        chk("first_cyc",  64'(bus.cycle_cnt), 64'd1);
        chk("first_len",  64'(cyc - m_e0), 64'd5);
        chk("first_err",  64'(bus.err_cnt), 64'd4);
        chk("first_mis",  64'(bus.mismatch_vec), 64'hF);
        tick();

        // 4b: no timeout for 1000 cycles; start pulse mid-RUN ignored
        launch(-1, -1, 0);
        drive_pc(1000, 20);
        chk("t4b_busy", 64'(bus.busy), 64'd1);
        chk("t4b_cyc",  64'(bus.cycle_cnt), 64'd1000);
        do_reset(1'b0);

        // 5: reset while comparing channel 1, then a clean run
        set_equal_data();
        launch(5, -1, 0);
        drive_pc(6, -1);
        tick();
        do_reset(1'b0);
        check_all("t5_rst", 0, 0, 0, 0, 0, 4'h0, 0);
        launch(-1, 3, 0);
        drive_pc(4, -1);
        wait_done(5);
        chk("t5_cause", 64'(bus.cause), 64'd2);
        tick();

        // rst and start together: rst wins
        do_reset(1'b1);
        chk("rst_start_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("rst_start_busy2", 64'(bus.busy), 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
